// File: rtl/fetch_pkg.sv
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared types and constants for the instruction fetch sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

   localparam int FETCH_PC_WIDTH    = 16;
   localparam int FETCH_INSTR_WIDTH = 32;
   localparam int INSTR_BYTES       = 4;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [FETCH_PC_WIDTH-1:0]    pc;
      logic [FETCH_INSTR_WIDTH-1:0] instr;
   } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
// ============================================================================
// Module : fetch_sequencer_if
// Brief  : Instruction-memory, redirect and IF/ID signals of the fetch sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_sequencer_if
   import fetch_pkg::*;
#(
   parameter int PC_WIDTH    = FETCH_PC_WIDTH,
   parameter int INSTR_WIDTH = FETCH_INSTR_WIDTH
) ();

   logic                   imem_req_valid;
   logic                   imem_req_ready;
   logic [PC_WIDTH-1:0]    imem_req_addr;
   logic                   imem_rsp_valid;
   logic [INSTR_WIDTH-1:0] imem_rsp_data;
   logic                   redirect_valid;
   logic [PC_WIDTH-1:0]    redirect_base;
   logic [PC_WIDTH-1:0]    redirect_offset;
   logic                   ifid_valid;
   logic                   ifid_ready;
   logic [PC_WIDTH-1:0]    ifid_pc;
   logic [INSTR_WIDTH-1:0] ifid_instr;
   logic                   busy;

   modport master (
      output imem_req_valid, imem_req_addr, ifid_valid, ifid_pc, ifid_instr, busy,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  redirect_valid, redirect_base, redirect_offset, ifid_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, ifid_valid, ifid_pc, ifid_instr, busy,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output redirect_valid, redirect_base, redirect_offset, ifid_ready
   );

endinterface

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module : fetch_queue
// Brief  : 2-entry FIFO of fetched {pc, instr} pairs with synchronous flush.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_queue
   import fetch_pkg::*;
(
   input  wire logic         clk,
   input  wire logic         rst,
   input  wire logic         flush,
   input  wire logic         push,
   input  wire fetch_entry_t push_data,
   input  wire logic         pop,
   output fetch_entry_t      head,
   output logic [1:0]        count,
   output logic              full,
   output logic              empty
);

   fetch_entry_t r_mem [0:1];
   logic         r_rd_ptr;
   logic         r_wr_ptr;
   logic [1:0]   r_count;
   logic         w_do_pop;
   logic         w_do_push;

   assign empty     = (r_count == 2'd0);
   assign full      = (r_count == 2'd2);
   assign count     = r_count;
   assign head      = r_mem[r_rd_ptr];
   assign w_do_pop  = pop && !empty;
   // A full queue still takes a push when the head leaves in the same cycle.
   assign w_do_push = push && (!full || w_do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            r_mem[i] <= '0;
         end
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (flush) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_do_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module : fetch_sequencer
// Brief  : Owns the fetch PC, issues one-at-a-time imem requests, buffers
//          responses for decode and restarts on branch/jump redirects.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int                  PC_WIDTH    = FETCH_PC_WIDTH,
   parameter int                  INSTR_WIDTH = FETCH_INSTR_WIDTH,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
   input wire logic          clk,
   input wire logic          rst,
   fetch_sequencer_if.master bus
);

   localparam logic [PC_WIDTH-1:0] c_instr_step = PC_WIDTH'(INSTR_BYTES);

   fetch_state_e        r_state;
   fetch_state_e        w_state_next;
   logic [PC_WIDTH-1:0] r_fetch_pc;
   logic [PC_WIDTH-1:0] w_fetch_pc_next;
   logic [PC_WIDTH-1:0] r_req_pc;
   logic [PC_WIDTH-1:0] w_req_pc_next;
   logic                r_stale;
   logic                w_stale_next;

   logic                w_inflight;
   logic [2:0]          w_slots_used;
   logic                w_req_valid;
   logic                w_req_fire;
   logic                w_rsp_take;
   logic                w_push;
   logic                w_pop;
   logic [PC_WIDTH-1:0] w_target_sum;
   logic [PC_WIDTH-1:0] w_target;

   fetch_entry_t        w_push_data;
   fetch_entry_t        w_head;
   logic [1:0]          w_q_count;
   logic                w_q_full;
   logic                w_q_empty;

   assign w_target_sum = bus.redirect_base + bus.redirect_offset;
   assign w_target     = {w_target_sum[PC_WIDTH-1:2], 2'b00};

   assign w_inflight   = (r_state == WAIT);
   assign w_slots_used = {1'b0, w_q_count} + {2'b00, w_inflight};
   assign w_req_valid  = (r_state == FETCH) && (w_slots_used < 3'd2);
   assign w_req_fire   = w_req_valid && bus.imem_req_ready;
   assign w_rsp_take   = (r_state == WAIT) && bus.imem_rsp_valid;
   // A response landing in a redirect cycle belongs to the abandoned path.
   assign w_push       = w_rsp_take && !r_stale && !bus.redirect_valid && (!w_q_full || w_pop);
   assign w_pop        = bus.ifid_valid && bus.ifid_ready;
   assign w_push_data  = '{pc: r_req_pc, instr: bus.imem_rsp_data};

   fetch_queue u_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (bus.redirect_valid),
      .push      (w_push),
      .push_data (w_push_data),
      .pop       (w_pop),
      .head      (w_head),
      .count     (w_q_count),
      .full      (w_q_full),
      .empty     (w_q_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= BOOT;
         r_fetch_pc <= RESET_PC;
         r_req_pc   <= RESET_PC;
         r_stale    <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_fetch_pc <= w_fetch_pc_next;
         r_req_pc   <= w_req_pc_next;
         r_stale    <= w_stale_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_fetch_pc_next = r_fetch_pc;
      w_req_pc_next   = r_req_pc;
      w_stale_next    = r_stale;

      case (r_state)
         BOOT: begin
            w_state_next = FETCH;
         end
         FETCH: begin
            if (w_req_fire) begin
               w_req_pc_next   = r_fetch_pc;
               w_fetch_pc_next = r_fetch_pc + c_instr_step;
               w_state_next    = WAIT;
            end
         end
         WAIT: begin
            if (bus.imem_rsp_valid) begin
               w_stale_next = 1'b0;
               w_state_next = FETCH;
            end
         end
         default: begin
            w_state_next = BOOT;
         end
      endcase

      // Redirect overrides the PC; any request still owed a response is marked stale.
      if (bus.redirect_valid) begin
         w_fetch_pc_next = w_target;
         if (w_req_fire || ((r_state == WAIT) && !bus.imem_rsp_valid)) begin
            w_stale_next = 1'b1;
         end
      end
   end

   assign bus.imem_req_valid = w_req_valid;
   assign bus.imem_req_addr  = r_fetch_pc;
   assign bus.busy           = w_inflight;
   assign bus.ifid_valid     = !w_q_empty;
   assign bus.ifid_pc        = w_head.pc;
   assign bus.ifid_instr     = w_head.instr;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module : tb_fetch_sequencer
// Brief  : Directed self-checking bench for fetch_sequencer with a simple imem.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;
   import fetch_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_sequencer_if #(.PC_WIDTH(16), .INSTR_WIDTH(32)) bus ();

   fetch_sequencer #(
      .PC_WIDTH    (16),
      .INSTR_WIDTH (32),
      .RESET_PC    (16'h0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_vec    = 0;
   int          n_err    = 0;
   bit          mem_auto = 1'b1;
   int          lat      = 1;
   int          mem_cnt  = 0;
   logic [15:0] mem_addr = '0;

   function automatic logic [31:0] mkdata(input logic [15:0] a);
      return {a ^ 16'h5A5A, a};
   endfunction

   // Instruction memory: answers each accepted request 'lat' cycles later.
   initial begin : mem_model
      logic        hs;
      logic [15:0] hs_addr;
      forever begin
         @(negedge clk);
         hs      = bus.imem_req_valid && bus.imem_req_ready;
         hs_addr = bus.imem_req_addr;
         @(posedge clk);
         #1;
         if (mem_auto) begin
            bus.imem_rsp_valid = 1'b0;
            if (rst) begin
               mem_cnt = 0;
            end else begin
               if (hs) begin
                  mem_cnt  = lat;
                  mem_addr = hs_addr;
               end
               if (mem_cnt > 0) begin
                  mem_cnt--;
                  if (mem_cnt == 0) begin
                     bus.imem_rsp_valid = 1'b1;
                     bus.imem_rsp_data  = mkdata(mem_addr);
                  end
               end
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input bit req_rdy, input bit ifid_rdy, input int latency, input bit auto_mem);
      rst                 = 1'b1;
      mem_auto            = auto_mem;
      lat                 = latency;
      bus.redirect_valid  = 1'b0;
      bus.redirect_base   = '0;
      bus.redirect_offset = '0;
      bus.imem_rsp_valid  = 1'b0;
      bus.imem_rsp_data   = '0;
      bus.imem_req_ready  = req_rdy;
      bus.ifid_ready      = ifid_rdy;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_vec++;
      if ({bus.imem_req_valid, bus.busy, bus.ifid_valid} !== 3'b000) begin
         n_err++; $display("FAIL reset_ctrl: got %b, want 000", {bus.imem_req_valid, bus.busy, bus.ifid_valid});
      end
      n_vec++;
      if (bus.imem_req_addr !== 16'h0000 || bus.ifid_pc !== 16'h0000 || bus.ifid_instr !== 32'h0) begin
         n_err++; $display("FAIL reset_data: got addr %h pc %h instr %h, want zeros", bus.imem_req_addr, bus.ifid_pc, bus.ifid_instr);
      end
      do_reset(1'b1, 1'b1, 1, 1'b1);
      @(negedge clk);
      n_vec++;
      if (bus.imem_req_valid !== 1'b0) begin
         n_err++; $display("FAIL boot_idle: got req_valid %b, want 0", bus.imem_req_valid);
      end
      @(negedge clk);
      n_vec++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 16'h0000) begin
         n_err++; $display("FAIL boot_first_req: got valid %b addr %h, want 1 0000", bus.imem_req_valid, bus.imem_req_addr);
      end
   endtask

   task automatic test_sequential_fetch();
      logic [15:0] exp_pc [3];
      int ri = 0;
      int ii = 0;
      exp_pc = '{16'h0000, 16'h0004, 16'h0008};
      do_reset(1'b1, 1'b1, 1, 1'b1);
      for (int c = 0; c < 40 && (ri < 3 || ii < 3); c++) begin
         @(negedge clk);
         if (bus.imem_req_valid && bus.imem_req_ready && ri < 3) begin
            n_vec++;
            if (bus.imem_req_addr !== exp_pc[ri]) begin
               n_err++; $display("FAIL seq_req%0d: got %h, want %h", ri, bus.imem_req_addr, exp_pc[ri]);
            end
            ri++;
         end
         if (bus.ifid_valid && bus.ifid_ready && ii < 3) begin
            n_vec++;
            if (bus.ifid_pc !== exp_pc[ii] || bus.ifid_instr !== mkdata(exp_pc[ii])) begin
               n_err++; $display("FAIL seq_ifid%0d: got %h/%h, want %h/%h", ii, bus.ifid_pc, bus.ifid_instr, exp_pc[ii], mkdata(exp_pc[ii]));
            end
            ii++;
         end
      end
      n_vec++;
      if (ri < 3 || ii < 3) begin
         n_err++; $display("FAIL seq_timeout: got %0d reqs %0d pops, want 3 3", ri, ii);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] exp_pc [2];
      int ri = 0;
      int ii = 0;
      exp_pc = '{16'h0000, 16'h0004};
      do_reset(1'b1, 1'b0, 1, 1'b1);
      repeat (10) @(negedge clk);
      n_vec++;
      if (bus.imem_req_valid !== 1'b0 || bus.busy !== 1'b0) begin
         n_err++; $display("FAIL bp_stall: got req_valid %b busy %b, want 0 0", bus.imem_req_valid, bus.busy);
      end
      n_vec++;
      if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== 16'h0000) begin
         n_err++; $display("FAIL bp_head: got valid %b pc %h, want 1 0000", bus.ifid_valid, bus.ifid_pc);
      end
      next_cycle();
      bus.ifid_ready = 1'b1;
      for (int c = 0; c < 30 && (ri < 1 || ii < 2); c++) begin
         @(negedge clk);
         if (bus.imem_req_valid && bus.imem_req_ready && ri < 1) begin
            n_vec++;
            if (bus.imem_req_addr !== 16'h0008) begin
               n_err++; $display("FAIL bp_resume: got %h, want 0008", bus.imem_req_addr);
            end
            ri++;
         end
         if (bus.ifid_valid && bus.ifid_ready && ii < 2) begin
            n_vec++;
            if (bus.ifid_pc !== exp_pc[ii]) begin
               n_err++; $display("FAIL bp_pop%0d: got %h, want %h", ii, bus.ifid_pc, exp_pc[ii]);
            end
            ii++;
         end
      end
      n_vec++;
      if (ri < 1 || ii < 2) begin
         n_err++; $display("FAIL bp_timeout: got %0d reqs %0d pops, want 1 2", ri, ii);
      end
   endtask

   task automatic test_redirect_wait();
      bit seen_req = 1'b0;
      bit seen_out = 1'b0;
      do_reset(1'b1, 1'b1, 3, 1'b1);
      for (int c = 0; c < 10 && !seen_req; c++) begin
         @(negedge clk);
         if (bus.imem_req_valid && bus.imem_req_ready) seen_req = 1'b1;
      end
      n_vec++;
      if (!seen_req || bus.imem_req_addr !== 16'h0000) begin
         n_err++; $display("FAIL rw_first_req: got seen %b addr %h, want 1 0000", seen_req, bus.imem_req_addr);
      end
      next_cycle();
      bus.redirect_valid  = 1'b1;
      bus.redirect_base   = 16'h0010;
      bus.redirect_offset = 16'hFFF8;
      @(negedge clk);
      n_vec++;
      if (bus.busy !== 1'b1) begin
         n_err++; $display("FAIL rw_busy: got %b, want 1", bus.busy);
      end
      next_cycle();
      bus.redirect_valid = 1'b0;
      seen_req = 1'b0;
      for (int c = 0; c < 30 && !seen_out; c++) begin
         @(negedge clk);
         if (bus.imem_req_valid && bus.imem_req_ready && !seen_req) begin
            n_vec++;
            if (bus.imem_req_addr !== 16'h0008) begin
               n_err++; $display("FAIL rw_target_req: got %h, want 0008", bus.imem_req_addr);
            end
            seen_req = 1'b1;
         end
         if (bus.ifid_valid) begin
            n_vec++;
            if (!seen_req || bus.ifid_pc !== 16'h0008 || bus.ifid_instr !== mkdata(16'h0008)) begin
               n_err++; $display("FAIL rw_first_out: got pc %h instr %h, want 0008 %h", bus.ifid_pc, bus.ifid_instr, mkdata(16'h0008));
            end
            seen_out = 1'b1;
         end
      end
      n_vec++;
      if (!seen_out) begin
         n_err++; $display("FAIL rw_timeout: got no output, want pc 0008");
      end
   endtask

   task automatic test_target_and_wrap();
      logic [15:0] exp_pc [2];
      int ri = 0;
      int ii = 0;
      exp_pc = '{16'hFFFC, 16'h0000};
      do_reset(1'b0, 1'b1, 1, 1'b1);
      repeat (2) @(negedge clk);
      n_vec++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 16'h0000) begin
         n_err++; $display("FAIL tw_held_req: got %b %h, want 1 0000", bus.imem_req_valid, bus.imem_req_addr);
      end
      next_cycle();
      bus.redirect_valid  = 1'b1;
      bus.redirect_base   = 16'h0020;
      bus.redirect_offset = 16'h0003;
      next_cycle();
      bus.redirect_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 16'h0020) begin
         n_err++; $display("FAIL tw_align: got %b %h, want 1 0020", bus.imem_req_valid, bus.imem_req_addr);
      end
      next_cycle();
      bus.redirect_valid  = 1'b1;
      bus.redirect_base   = 16'hFFF0;
      bus.redirect_offset = 16'h000C;
      next_cycle();
      bus.redirect_valid = 1'b0;
      bus.imem_req_ready = 1'b1;
      for (int c = 0; c < 30 && (ri < 2 || ii < 2); c++) begin
         @(negedge clk);
         if (bus.imem_req_valid && bus.imem_req_ready && ri < 2) begin
            n_vec++;
            if (bus.imem_req_addr !== exp_pc[ri]) begin
               n_err++; $display("FAIL tw_req%0d: got %h, want %h", ri, bus.imem_req_addr, exp_pc[ri]);
            end
            ri++;
         end
         if (bus.ifid_valid && bus.ifid_ready && ii < 2) begin
            n_vec++;
            if (bus.ifid_pc !== exp_pc[ii]) begin
               n_err++; $display("FAIL tw_ifid%0d: got %h, want %h", ii, bus.ifid_pc, exp_pc[ii]);
            end
            ii++;
         end
      end
      n_vec++;
      if (ri < 2 || ii < 2) begin
         n_err++; $display("FAIL tw_timeout: got %0d reqs %0d pops, want 2 2", ri, ii);
      end
   endtask

   task automatic test_back_to_back();
      bit seen_req = 1'b0;
      bit seen_out = 1'b0;
      do_reset(1'b0, 1'b1, 1, 1'b1);
      repeat (2) @(negedge clk);
      next_cycle();
      bus.redirect_valid  = 1'b1;
      bus.redirect_base   = 16'h0100;
      bus.redirect_offset = 16'h0000;
      next_cycle();
      bus.redirect_base   = 16'h0200;
      bus.redirect_offset = 16'h0004;
      next_cycle();
      bus.redirect_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus.imem_req_addr !== 16'h0204) begin
         n_err++; $display("FAIL b2b_last_wins: got %h, want 0204", bus.imem_req_addr);
      end
      // Redirect in the very cycle the old request is accepted.
      next_cycle();
      bus.imem_req_ready  = 1'b1;
      bus.redirect_valid  = 1'b1;
      bus.redirect_base   = 16'h0300;
      bus.redirect_offset = 16'h0000;
      next_cycle();
      bus.redirect_valid = 1'b0;
      for (int c = 0; c < 30 && !seen_out; c++) begin
         @(negedge clk);
         if (bus.imem_req_valid && bus.imem_req_ready && !seen_req) begin
            n_vec++;
            if (bus.imem_req_addr !== 16'h0300) begin
               n_err++; $display("FAIL b2b_accept_req: got %h, want 0300", bus.imem_req_addr);
            end
            seen_req = 1'b1;
         end
         if (bus.ifid_valid) begin
            n_vec++;
            if (bus.ifid_pc !== 16'h0300 || bus.ifid_instr !== mkdata(16'h0300)) begin
               n_err++; $display("FAIL b2b_accept_out: got %h %h, want 0300 %h", bus.ifid_pc, bus.ifid_instr, mkdata(16'h0300));
            end
            seen_out = 1'b1;
         end
      end
      n_vec++;
      if (!seen_out) begin
         n_err++; $display("FAIL b2b_timeout: got no output, want pc 0300");
      end
   endtask

   task automatic test_redirect_collision();
      bit seen_req = 1'b0;
      do_reset(1'b1, 1'b0, 1, 1'b0);
      for (int c = 0; c < 10 && !seen_req; c++) begin
         @(negedge clk);
         if (bus.imem_req_valid && bus.imem_req_ready) seen_req = 1'b1;
      end
      n_vec++;
      if (!seen_req || bus.imem_req_addr !== 16'h0000) begin
         n_err++; $display("FAIL col_first_req: got seen %b addr %h, want 1 0000", seen_req, bus.imem_req_addr);
      end
      next_cycle();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mkdata(16'h0000);
      next_cycle();
      bus.imem_rsp_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 16'h0004) begin
         n_err++; $display("FAIL col_second_req: got %b %h, want 1 0004", bus.imem_req_valid, bus.imem_req_addr);
      end
      next_cycle();
      bus.imem_rsp_valid  = 1'b1;
      bus.imem_rsp_data   = mkdata(16'h0004);
      bus.redirect_valid  = 1'b1;
      bus.redirect_base   = 16'h0040;
      bus.redirect_offset = 16'h0000;
      bus.ifid_ready      = 1'b1;
      @(negedge clk);
      n_vec++;
      if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== 16'h0000 || bus.busy !== 1'b1) begin
         n_err++; $display("FAIL col_pre: got valid %b pc %h busy %b, want 1 0000 1", bus.ifid_valid, bus.ifid_pc, bus.busy);
      end
      next_cycle();
      bus.imem_rsp_valid = 1'b0;
      bus.redirect_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus.ifid_valid !== 1'b0 || bus.busy !== 1'b0) begin
         n_err++; $display("FAIL col_flush: got valid %b busy %b, want 0 0", bus.ifid_valid, bus.busy);
      end
      n_vec++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 16'h0040) begin
         n_err++; $display("FAIL col_target: got %b %h, want 1 0040", bus.imem_req_valid, bus.imem_req_addr);
      end
      next_cycle();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mkdata(16'h0040);
      next_cycle();
      bus.imem_rsp_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== 16'h0040 || bus.ifid_instr !== mkdata(16'h0040)) begin
         n_err++; $display("FAIL col_not_stale: got %b %h %h, want 1 0040 %h", bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, mkdata(16'h0040));
      end
      mem_auto = 1'b1;
   endtask

   task automatic test_reset_midway();
      bit found = 1'b0;
      bit seen_req = 1'b0;
      bit seen_out = 1'b0;
      do_reset(1'b1, 1'b0, 3, 1'b1);
      for (int c = 0; c < 30 && !found; c++) begin
         @(negedge clk);
         if (bus.ifid_valid && bus.busy) found = 1'b1;
      end
      n_vec++;
      if (!found) begin
         n_err++; $display("FAIL rm_setup: got no WAIT with queued entry, want one");
      end
      rst = 1'b1;
      #1;
      n_vec++;
      if ({bus.imem_req_valid, bus.busy, bus.ifid_valid} !== 3'b000 || bus.ifid_pc !== 16'h0 || bus.ifid_instr !== 32'h0) begin
         n_err++; $display("FAIL rm_clear: got ctrl %b pc %h instr %h, want 000 0000 0", {bus.imem_req_valid, bus.busy, bus.ifid_valid}, bus.ifid_pc, bus.ifid_instr);
      end
      n_vec++;
      if (bus.imem_req_addr !== 16'h0000) begin
         n_err++; $display("FAIL rm_addr: got %h, want 0000", bus.imem_req_addr);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      bus.ifid_ready = 1'b1;
      for (int c = 0; c < 30 && !seen_out; c++) begin
         @(negedge clk);
         if (bus.imem_req_valid && bus.imem_req_ready && !seen_req) begin
            n_vec++;
            if (bus.imem_req_addr !== 16'h0000) begin
               n_err++; $display("FAIL rm_restart_req: got %h, want 0000", bus.imem_req_addr);
            end
            seen_req = 1'b1;
         end
         if (bus.ifid_valid) begin
            n_vec++;
            if (bus.ifid_pc !== 16'h0000) begin
               n_err++; $display("FAIL rm_restart_out: got %h, want 0000", bus.ifid_pc);
            end
            seen_out = 1'b1;
         end
      end
      n_vec++;
      if (!seen_out) begin
         n_err++; $display("FAIL rm_timeout: got no output, want pc 0000");
      end
   endtask

   initial begin
      bus.imem_req_ready  = 1'b1;
      bus.imem_rsp_valid  = 1'b0;
      bus.imem_rsp_data   = '0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_base   = '0;
      bus.redirect_offset = '0;
      bus.ifid_ready      = 1'b1;
      test_reset();
      test_sequential_fetch();
      test_backpressure();
      test_redirect_wait();
      test_target_and_wrap();
      test_back_to_back();
      test_redirect_collision();
      test_reset_midway();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
